mux_n_to_1_reg: RTL

Parametrised N-to-1 one-hot-select multiplexer that succeeds the mux_2/3/4_to_1 family. It has a registered, flow-controlled output: a valid/ready handshake with a 2-entry skid buffer.
- The "hold last value when no select asserted" semantic is kept, but implemented as an explicit hold register instead of a combinational feedback latch.
- Used on datapath source selects (ALU operand, RF write data, memory instruction source) where select timing is not aligned with consumption.

---
 rtl/mux_n_to_1_reg_if.sv | 24 ++
 rtl/mux_n_to_1_reg.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_reg_if.sv
// Handshake bundle for mux_n_to_1_reg: the upstream select/data port and the
// downstream registered valid/ready port.
interface mux_n_to_1_reg_if #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_INPUTS  = 4
);
    logic [NUM_INPUTS*WORD_LENGTH-1:0] data_in;
    logic [NUM_INPUTS-1:0]             sel;
    logic                              in_valid;
    logic                              in_ready;
    logic [WORD_LENGTH-1:0]            out;
    logic                              out_valid;
    logic                              out_ready;

    modport master (
        output data_in, sel, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  data_in, sel, in_valid, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/mux_n_to_1_reg.sv
// N-to-1 one-hot (lowest-index priority) mux with a registered valid/ready
// output and 2-entry skid buffer. Define MUX_SEL_CHECK_EN to add sticky sel_err.
module mux_n_to_1_reg #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_INPUTS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_n_to_1_reg_if.slave      bus
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic                 sel_err
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [NUM_INPUTS-1:0]  SEL_ZERO  = {NUM_INPUTS{1'b0}};
    localparam logic [WORD_LENGTH-1:0] WORD_ZERO = {WORD_LENGTH{1'b0}};

    state_t                 state_r;
    logic [WORD_LENGTH-1:0] out_r;
    logic [WORD_LENGTH-1:0] skid_r;
    logic [WORD_LENGTH-1:0] hold_r;
    logic                   out_valid_r;
    logic                   in_ready_r;

    logic [WORD_LENGTH-1:0] word_s;
    logic                   accept_s;
    logic                   drain_s;
    logic                   sel_any_s;

    // Walk from the top index down so the lowest set bit is the last to win.
    function automatic logic [WORD_LENGTH-1:0] pick_word(
        input logic [NUM_INPUTS*WORD_LENGTH-1:0] data,
        input logic [NUM_INPUTS-1:0]             one_hot,
        input logic [WORD_LENGTH-1:0]            fallback
    );
        logic [WORD_LENGTH-1:0] w;
        w = fallback;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            w = one_hot[i] ? data[i*WORD_LENGTH +: WORD_LENGTH] : w;
        end
        return w;
    endfunction

    // Word selection and handshake qualifiers.
    always_comb begin
        word_s    = pick_word(bus.data_in, bus.sel, hold_r);
        sel_any_s = (bus.sel != SEL_ZERO);
        accept_s  = bus.in_valid & in_ready_r;
        drain_s   = out_valid_r & bus.out_ready;
    end

    // Skid-buffer state machine, hold register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            out_r       <= WORD_ZERO;
            skid_r      <= WORD_ZERO;
            hold_r      <= WORD_ZERO;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            if (accept_s && sel_any_s) begin
                hold_r <= word_s;
            end
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        out_r       <= word_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ONE;
                    end
                end
                ONE: begin
                    if (accept_s && drain_s) begin
                        out_r <= word_s;
                    end else if (accept_s) begin
                        skid_r     <= word_s;
                        in_ready_r <= 1'b0;
                        state_r    <= TWO;
                    end else if (drain_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain_s) begin
                        out_r      <= skid_r;
                        in_ready_r <= 1'b1;
                        state_r    <= ONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= EMPTY;
                end
            endcase
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.in_ready  = in_ready_r;

`ifdef MUX_SEL_CHECK_EN
    logic sel_err_r;

    // More than one bit set exactly when clearing the lowest set bit leaves something.
    function automatic logic multi_hot(input logic [NUM_INPUTS-1:0] v);
        return (v & (v - {{(NUM_INPUTS-1){1'b0}}, 1'b1})) != SEL_ZERO;
    endfunction

    // Sticky multi-hot detector, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (accept_s && multi_hot(bus.sel)) begin
            sel_err_r <= 1'b1;
        end
    end

    assign sel_err = sel_err_r;
`endif

endmodule
